// File: rtl/xgmii_loopback_pkg.sv
// Shared constants and types for the XGMII loopback self-test engine.
// Idle constants are defined per 32-bit lane group and replicated by users.
package xgmii_loopback_pkg;

    localparam logic [31:0] IDLE_WORD = 32'h0707_0707;
    localparam logic [3:0]  IDLE_CTRL = 4'hF;

    // Entry 0 is emitted first after a restart.
    localparam logic [3:0][31:0] PATTERN_TABLE = {
        32'h4A4F_414F, 32'hBAAD_F00D, 32'hCAFE_BABE, 32'h0FA5_8D31
    };

    typedef enum logic [1:0] {
        MODE_TABLE     = 2'd0,
        MODE_INCR      = 2'd1,
        MODE_PRBS31    = 2'd2,
        MODE_TABLE_ALT = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOCK,
        CHECK,
        DRAIN,
        TIMEOUT
    } state_e;

    localparam int PRBS_TAP_HI = 31;
    localparam int PRBS_TAP_LO = 28;

endpackage

// File: rtl/xgmii_pattern_gen.sv
// Test-pattern source: table, incrementing or PRBS31 words.
// On restart the first word is presented combinationally and state jumps to the second.
module xgmii_pattern_gen
    import xgmii_loopback_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  mode_e                 mode,
    input  logic                  restart,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int LANES = DATA_WIDTH / 32;

    logic [1:0]            tbl_idx;
    logic [DATA_WIDTH-1:0] incr_val;
    logic [30:0]           lfsr;
    logic [30:0]           lfsr_next;
    logic [DATA_WIDTH-1:0] prbs_word;

    // Run the x^31+x^28+1 LFSR DATA_WIDTH steps; first bit produced lands in the MSB.
    function automatic logic [DATA_WIDTH+30:0] prbs_step(input logic [30:0] s);
        logic [30:0]           r;
        logic [DATA_WIDTH-1:0] w;
        logic                  b;
        r = s;
        w = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            b    = r[PRBS_TAP_HI-1] ^ r[PRBS_TAP_LO-1];
            r    = {r[29:0], b};
            w[i] = b;
        end
        return {w, r};
    endfunction

    always_comb begin
        {prbs_word, lfsr_next} = prbs_step(restart ? 31'h7FFF_FFFF : lfsr);
        data = '0;
        case (mode)
            MODE_INCR:   data = restart ? DATA_WIDTH'(1) : incr_val;
            MODE_PRBS31: data = prbs_word;
            default:     data = {LANES{PATTERN_TABLE[restart ? 2'd0 : tbl_idx]}};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_idx  <= '0;
            incr_val <= '0;
            lfsr     <= '1;
        end else if (restart) begin
            tbl_idx  <= 2'd1;
            incr_val <= DATA_WIDTH'(2);
            lfsr     <= lfsr_next;
        end else if (advance) begin
            tbl_idx  <= tbl_idx + 2'd1;
            incr_val <= incr_val + DATA_WIDTH'(1);
            lfsr     <= lfsr_next;
        end
    end

endmodule

// File: rtl/xgmii_loopback_checker.sv
// XGMII loopback self-test: generates a stream, locks onto the loop delay, counts mismatches.
// Optional macro XGMII_LOOPBACK_ERR_INJECT_EN adds inject_err to flip bit 0 of the next tx word.
module xgmii_loopback_checker
    import xgmii_loopback_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int CTRL_WIDTH  = DATA_WIDTH / 8,
    parameter int MAX_LATENCY = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                           tx_clk,
    input  logic                           tx_rst_n,
    input  logic                           start,
    input  logic                           stop,
    input  logic [1:0]                     cfg_mode,
    output logic [DATA_WIDTH-1:0]          xgmii_txd,
    output logic [CTRL_WIDTH-1:0]          xgmii_txc,
    input  logic [DATA_WIDTH-1:0]          xgmii_rxd,
    input  logic [CTRL_WIDTH-1:0]          xgmii_rxc,
    output logic                           busy,
    output logic                           locked,
    output logic                           timeout,
    output logic [$clog2(MAX_LATENCY)-1:0] latency,
    output logic [CNT_WIDTH-1:0]           word_count,
    output logic [CNT_WIDTH-1:0]           error_count,
    output logic                           error
`ifdef XGMII_LOOPBACK_ERR_INJECT_EN
    ,
    input  logic                           inject_err
`endif
);

    localparam int LAT_W  = $clog2(MAX_LATENCY);
    localparam int HIST_W = DATA_WIDTH + CTRL_WIDTH;
    localparam logic [DATA_WIDTH-1:0] IDLE_TXD = {(DATA_WIDTH / 32){IDLE_WORD}};
    localparam logic [CTRL_WIDTH-1:0] IDLE_TXC = {(CTRL_WIDTH / 4){IDLE_CTRL}};
    localparam logic [LAT_W-1:0]      LAT_LAST = LAT_W'(MAX_LATENCY - 2);

    state_e                state;
    mode_e                 mode_q;
    mode_e                 gen_mode;
    logic [HIST_W-1:0]     hist [MAX_LATENCY];
    logic [HIST_W-1:0]     hist_in;
    logic [HIST_W-1:0]     expected;
    logic [DATA_WIDTH-1:0] txd_clean;
    logic [DATA_WIDTH-1:0] gen_data;
    logic [DATA_WIDTH-1:0] tx_word;
    logic [LAT_W-1:0]      wr_ptr;
    logic [LAT_W-1:0]      rd_ptr;
    logic [LAT_W-1:0]      lat_cnt;
    logic [LAT_W-1:0]      lat_sel;
    logic [LAT_W-1:0]      drain_cnt;
    logic                  start_ok;
    logic                  lock_hit;
    logic                  timeout_hit;
    logic                  generating;
    logic                  cmp_en;
    logic                  mismatch;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign start_ok    = start && !stop && (state == IDLE);
    assign lock_hit    = (state == WAIT_LOCK) && !stop && (xgmii_rxc == '0);
    assign timeout_hit = (state == WAIT_LOCK) && !stop && !lock_hit && (lat_cnt == LAT_LAST);
    assign generating  = start_ok ||
                         ((state == WAIT_LOCK || state == CHECK) && !stop && !timeout_hit);
    assign gen_mode    = start_ok ? mode_e'(cfg_mode) : mode_q;
    assign busy        = (state != IDLE);

`ifdef XGMII_LOOPBACK_ERR_INJECT_EN
    assign tx_word = gen_data ^ {{(DATA_WIDTH-1){1'b0}},
                                 inject_err && (state == WAIT_LOCK || state == CHECK)};
`else
    assign tx_word = gen_data;
`endif

    // The entry at wr_ptr is still stale this cycle, so a zero delay bypasses to the live word.
    assign lat_sel  = (state == WAIT_LOCK) ? lat_cnt : latency;
    assign rd_ptr   = wr_ptr - lat_sel;
    assign hist_in  = {txd_clean, xgmii_txc};
    assign expected = (lat_sel == '0) ? hist_in : hist[rd_ptr];
    assign cmp_en   = lock_hit || (state == CHECK) || (state == DRAIN);
    assign mismatch = cmp_en && ({xgmii_rxd, xgmii_rxc} != expected);

    xgmii_pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_gen (
        .clk     (tx_clk),
        .rst_n   (tx_rst_n),
        .mode    (gen_mode),
        .restart (start_ok),
        .advance (generating && !start_ok),
        .data    (gen_data)
    );

    always_ff @(posedge tx_clk) begin
        hist[wr_ptr] <= hist_in;
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state       <= IDLE;
            mode_q      <= MODE_TABLE;
            xgmii_txd   <= IDLE_TXD;
            txd_clean   <= IDLE_TXD;
            xgmii_txc   <= IDLE_TXC;
            wr_ptr      <= '0;
            lat_cnt     <= '0;
            latency     <= '0;
            drain_cnt   <= '0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
            word_count  <= '0;
            error_count <= '0;
            error       <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + LAT_W'(1);
            error  <= mismatch;
            if (cmp_en) begin
                word_count <= sat_inc(word_count);
                if (mismatch) error_count <= sat_inc(error_count);
            end
            if (generating) begin
                xgmii_txd <= tx_word;
                txd_clean <= gen_data;
                xgmii_txc <= '0;
            end else begin
                xgmii_txd <= IDLE_TXD;
                txd_clean <= IDLE_TXD;
                xgmii_txc <= IDLE_TXC;
            end
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state       <= WAIT_LOCK;
                        mode_q      <= mode_e'(cfg_mode);
                        lat_cnt     <= '0;
                        latency     <= '0;
                        locked      <= 1'b0;
                        timeout     <= 1'b0;
                        word_count  <= '0;
                        error_count <= '0;
                    end
                end
                WAIT_LOCK: begin
                    lat_cnt <= lat_cnt + LAT_W'(1);
                    if (stop) begin
                        state <= IDLE;
                    end else if (lock_hit) begin
                        latency <= lat_cnt;
                        locked  <= 1'b1;
                        state   <= CHECK;
                    end else if (timeout_hit) begin
                        timeout <= 1'b1;
                        state   <= TIMEOUT;
                    end
                end
                CHECK: begin
                    if (stop) begin
                        drain_cnt <= latency;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) state <= IDLE;
                    else drain_cnt <= drain_cnt - LAT_W'(1);
                end
                TIMEOUT: begin
                    if (start || stop) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xgmii_loopback_checker.sv
// Directed bench for xgmii_loopback_checker with a tx-word and error-pulse scoreboard.
module tb_xgmii_loopback_checker;

    localparam int DW   = 64;
    localparam int CW   = 8;
    localparam int ML   = 64;
    localparam int CNTW = 16;
    localparam int LW   = 6;
    localparam logic [DW-1:0]    IDLE_D    = 64'h0707_0707_0707_0707;
    localparam logic [DW+CW-1:0] IDLE_PAIR = {64'h0707_0707_0707_0707, 8'hFF};

    logic            tx_clk   = 1'b0;
    logic            tx_rst_n = 1'b0;
    logic            start    = 1'b0;
    logic            stop     = 1'b0;
    logic [1:0]      cfg_mode = 2'd0;
    logic [DW-1:0]   xgmii_txd;
    logic [CW-1:0]   xgmii_txc;
    logic [DW-1:0]   xgmii_rxd;
    logic [CW-1:0]   xgmii_rxc;
    logic            busy;
    logic            locked;
    logic            timeout;
    logic            error;
    logic [LW-1:0]   latency;
    logic [CNTW-1:0] word_count;
    logic [CNTW-1:0] error_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lb_delay = 0;
    bit rx_stuck = 1'b0;
    bit flip5    = 1'b0;
    bit exp_e;

    logic [DW+CW-1:0] pd0 = IDLE_PAIR;
    logic [DW+CW-1:0] pd1 = IDLE_PAIR;
    logic [DW+CW-1:0] pd2 = IDLE_PAIR;
    logic [DW+CW-1:0] rx_pair;

    logic [DW-1:0] exp_tx[$];
    int            exp_err[$];

    xgmii_loopback_checker #(
        .DATA_WIDTH  (DW),
        .CTRL_WIDTH  (CW),
        .MAX_LATENCY (ML),
        .CNT_WIDTH   (CNTW)
    ) dut (
        .tx_clk      (tx_clk),
        .tx_rst_n    (tx_rst_n),
        .start       (start),
        .stop        (stop),
        .cfg_mode    (cfg_mode),
        .xgmii_txd   (xgmii_txd),
        .xgmii_txc   (xgmii_txc),
        .xgmii_rxd   (xgmii_rxd),
        .xgmii_rxc   (xgmii_rxc),
        .busy        (busy),
        .locked      (locked),
        .timeout     (timeout),
        .latency     (latency),
        .word_count  (word_count),
        .error_count (error_count),
        .error       (error)
`ifdef XGMII_LOOPBACK_ERR_INJECT_EN
        ,
        .inject_err  (1'b0)
`endif
    );

    always #5 tx_clk = ~tx_clk;

    // Loopback channel: 3-register pipe or direct wire, with optional corruption.
    always @(posedge tx_clk) begin
        pd0 <= {xgmii_txd, xgmii_txc};
        pd1 <= pd0;
        pd2 <= pd1;
        cyc <= cyc + 1;
    end

    always_comb begin
        rx_pair   = (lb_delay == 3) ? pd2 : {xgmii_txd, xgmii_txc};
        xgmii_rxd = rx_pair[DW+CW-1:CW] ^ (flip5 ? 64'h20 : 64'h0);
        xgmii_rxc = rx_stuck ? 8'hFF : rx_pair[CW-1:0];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] tbl_word(input int i);
        logic [31:0] w;
        case (i % 4)
            0:       w = 32'h0FA5_8D31;
            1:       w = 32'hCAFE_BABE;
            2:       w = 32'hBAAD_F00D;
            default: w = 32'h4A4F_414F;
        endcase
        return {w, w};
    endfunction

    task automatic push_table(input int n);
        for (int i = 0; i < n; i++) exp_tx.push_back(tbl_word(i));
    endtask

    task automatic push_incr(input int n);
        for (int i = 0; i < n; i++) exp_tx.push_back(64'(i + 1));
    endtask

    task automatic push_prbs(input int n);
        logic [30:0]   r;
        logic [DW-1:0] w;
        logic          nb;
        r = '1;
        for (int i = 0; i < n; i++) begin
            for (int b = DW - 1; b >= 0; b--) begin
                nb   = r[30] ^ r[27];
                r    = {r[29:0], nb};
                w[b] = nb;
            end
            exp_tx.push_back(w);
        end
    endtask

    task automatic tick();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] m);
        cfg_mode = m;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Monitor: every data word on tx is popped against the model; error pulses against flip log.
    always @(negedge tx_clk) begin
        if (tx_rst_n) begin
            if (xgmii_txc == '0) begin
                if (exp_tx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_word: unexpected word %h, none expected", xgmii_txd);
                end else begin
                    chk("tx_word", xgmii_txd, exp_tx.pop_front());
                end
            end
            exp_e = (exp_err.size() != 0) && (exp_err[0] == cyc);
            if (error || exp_e) begin
                chk("error_pulse", 64'(error), 64'(exp_e));
                if (exp_e) void'(exp_err.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_txd", xgmii_txd, IDLE_D);
        chk("rst_txc", 64'(xgmii_txc), 64'hFF);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);
        @(negedge tx_clk) tx_rst_n = 1'b1;
        tick();
        tick();

        // 3-cycle loop, table mode, 50 compares then stop
        lb_delay = 3;
        push_table(53);
        do_start(2'd0);
        chk("t1_first_word", xgmii_txd, 64'h0FA5_8D31_0FA5_8D31);
        chk("t1_txc", 64'(xgmii_txc), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        repeat (52) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (5) tick();
        chk("t1_busy_end", 64'(busy), 64'd0);
        chk("t1_locked", 64'(locked), 64'd1);
        chk("t1_latency", 64'(latency), 64'd3);
        chk("t1_word_count", 64'(word_count), 64'd54);
        chk("t1_error_count", 64'(error_count), 64'd0);
        chk("t1_txd_idle", xgmii_txd, IDLE_D);

        // direct loop, incrementing mode
        lb_delay = 0;
        push_incr(10);
        do_start(2'd1);
        chk("t2_first_word", xgmii_txd, 64'd1);
        repeat (9) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (3) tick();
        chk("t2_latency", 64'(latency), 64'd0);
        chk("t2_locked", 64'(locked), 64'd1);
        chk("t2_word_count", 64'(word_count), 64'd11);
        chk("t2_error_count", 64'(error_count), 64'd0);

        // control stuck at idle: timeout 63 cycles after first word
        rx_stuck = 1'b1;
        push_table(63);
        do_start(2'd0);
        repeat (62) tick();
        chk("t3_timeout_early", 64'(timeout), 64'd0);
        tick();
        chk("t3_timeout", 64'(timeout), 64'd1);
        chk("t3_txd_idle", xgmii_txd, IDLE_D);
        chk("t3_txc_idle", 64'(xgmii_txc), 64'hFF);
        chk("t3_locked", 64'(locked), 64'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        chk("t3_busy_idle", 64'(busy), 64'd0);
        chk("t3_timeout_held", 64'(timeout), 64'd1);
        rx_stuck = 1'b0;

        // PRBS31, two corrupted words
        lb_delay = 3;
        push_prbs(30);
        do_start(2'd2);
        chk("t4_prbs_first", xgmii_txd, 64'h0000_000E_0000_00FC);
        repeat (9) tick();
        flip5 = 1'b1;
        exp_err.push_back(cyc + 1);
        tick();
        flip5 = 1'b0;
        repeat (9) tick();
        flip5 = 1'b1;
        exp_err.push_back(cyc + 1);
        tick();
        flip5 = 1'b0;
        repeat (9) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (5) tick();
        chk("t4_error_count", 64'(error_count), 64'd2);
        chk("t4_word_count", 64'(word_count), 64'd31);

        // seven errors, then asynchronous reset mid-check
        push_table(13);
        do_start(2'd0);
        repeat (4) tick();
        for (int i = 0; i < 7; i++) begin
            flip5 = 1'b1;
            exp_err.push_back(cyc + 1);
            tick();
        end
        flip5 = 1'b0;
        chk("t5_error_count_pre", 64'(error_count), 64'd7);
        tick();
        #5;
        tx_rst_n = 1'b0;
        #1;
        chk("t5_rst_txd", xgmii_txd, IDLE_D);
        chk("t5_rst_txc", 64'(xgmii_txc), 64'hFF);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_locked", 64'(locked), 64'd0);
        chk("t5_rst_latency", 64'(latency), 64'd0);
        chk("t5_rst_word_count", 64'(word_count), 64'd0);
        chk("t5_rst_error_count", 64'(error_count), 64'd0);
        chk("t5_rst_error", 64'(error), 64'd0);
        @(negedge tx_clk) tx_rst_n = 1'b1;
        repeat (5) tick();
        push_table(20);
        do_start(2'd0);
        repeat (19) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (5) tick();
        chk("t5_clean_error_count", 64'(error_count), 64'd0);
        chk("t5_clean_word_count", 64'(word_count), 64'd21);
        chk("t5_clean_latency", 64'(latency), 64'd3);

        // start and stop together while idle
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("t6_busy", 64'(busy), 64'd0);
        tick();
        chk("t6_busy_later", 64'(busy), 64'd0);
        chk("t6_txc_idle", 64'(xgmii_txc), 64'hFF);
        chk("t6_word_count_held", 64'(word_count), 64'd21);

        repeat (3) tick();
        chk("tx_queue_drained", 64'(exp_tx.size()), 64'd0);
        chk("err_queue_drained", 64'(exp_err.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xgmii_loopback_checker.md
Name: xgmii_loopback_checker

Overview:
- Synthesizable XGMII loopback self-test engine for the 10G PHY path. Sits in front of eth_phy_10g on the tx_clk domain.
- Generates a parametrised test stream on xgmii_txd/xgmii_txc and receives the looped-back xgmii_rxd/xgmii_rxc.
- Measures loopback latency in cycles, then compares every received word against the transmitted history and counts mismatches.

Parameters:
- DATA_WIDTH, 64, XGMII data width; multiple of 32.
- CTRL_WIDTH, DATA_WIDTH/8, control bits, one per byte lane.
- MAX_LATENCY, 64, history depth and latency timeout in cycles; power of 2, at least 4.
- CNT_WIDTH, 16, width of the word and error counters.

Ports:
- tx_clk  in  1  clock
- tx_rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a test when idle
- stop  in  1  single-cycle pulse; ends the test
- cfg_mode  in  2  0 = table, 1 = incrementing, 2 = PRBS31, 3 = table
- xgmii_txd  out  DATA_WIDTH  generated data, registered
- xgmii_txc  out  CTRL_WIDTH  generated control, registered
- xgmii_rxd  in  DATA_WIDTH  looped-back data
- xgmii_rxc  in  CTRL_WIDTH  looped-back control
- busy  out  1  state is not IDLE
- locked  out  1  latency captured; compare is active
- timeout  out  1  no data returned within MAX_LATENCY cycles
- latency  out  $clog2(MAX_LATENCY)  measured loop delay in cycles
- word_count  out  CNT_WIDTH  number of words compared; saturates
- error_count  out  CNT_WIDTH  number of mismatched words; saturates
- error  out  1  one-cycle pulse per mismatch

Behaviour:
- Reset values:
  - txd = IDLE_WORD (0x07 in every byte), txc = all ones.
  - All status outputs and counters 0; state IDLE.
- Every driven txd/txc pair is written each cycle into a circular history of MAX_LATENCY entries, in all states.
- States:
  - IDLE: drive idle. On start, go to WAIT_LOCK, clear all counters/flags and reset the generator seed.
  - WAIT_LOCK: the first pattern word appears on txd the cycle after start, with txc = 0. The latency counter is 0 in that cycle and increments each cycle. On the first sampled rxc == 0, capture the counter into latency, set locked and go to CHECK; that word is also the first compared word. If the counter reaches MAX_LATENCY-1 with no lock, go to TIMEOUT.
  - CHECK: keep generating. Each cycle compare {rxd,rxc} with history[wr_ptr - latency], modulo MAX_LATENCY. word_count increments; on mismatch, error_count increments and error pulses. Both counters saturate at all ones.
  - TIMEOUT: drive idle, timeout = 1. On stop or start, go to IDLE; start does not re-arm in the same cycle.
  - DRAIN: entered on stop from WAIT_LOCK or CHECK. Tx drives idle from the next cycle. If locked, comparison continues for exactly latency+1 cycles, then IDLE. If not locked, go straight to IDLE.
- Results (latency, counters, locked, timeout) hold in IDLE until the next start.
- start and stop in the same cycle: stop wins. start is ignored outside IDLE and TIMEOUT.
- Generator patterns:
  - Table mode: 32-bit words 0x0FA58D31, 0xCAFEBABE, 0xBAADF00D, 0x4A4F414F, each replicated across DATA_WIDTH, advancing one entry per cycle and wrapping.
  - Incrementing mode: starts at 1, +1 per cycle, wraps modulo 2^DATA_WIDTH.
  - PRBS31 mode: x^31+x^28+1, seed all ones, advanced DATA_WIDTH bits per cycle, MSB first.
- cfg_mode is sampled only on start.
- Reset asserted mid-test: everything returns to reset values immediately (asynchronous assertion); the history contents are don't-care.

Optional Feature:
- Macro: XGMII_LOOPBACK_ERR_INJECT_EN.
- When defined:
  - Adds input inject_err (1 bit).
  - A pulse in WAIT_LOCK or CHECK flips bit 0 of the next generated txd word.
  - The history stores the uncorrupted word, so exactly one error is counted once that word returns.
- When undefined: the port is absent and the generator output is unmodified.

Decomposition:
- Package xgmii_loopback_pkg holds:
  - IDLE_WORD and IDLE_CTRL constants;
  - the 4-entry pattern table;
  - the mode enum;
  - the state enum {IDLE, WAIT_LOCK, CHECK, DRAIN, TIMEOUT};
  - PRBS31 tap positions.
- Sub-module xgmii_pattern_gen: mode input, seed/restart input, advance enable; outputs the next data word.

Test Plan:
- Loopback through a 3-register pipeline, mode 0, run 50 cycles, stop -> latency = 3, locked = 1, word_count = 50 + 4 drain words, error_count = 0.
- Mode 1 with a combinational loop -> latency = 0; compared rxd sequence is 1, 2, 3, …; error_count = 0.
- rxc held at 0xFF after start -> timeout = 1 on cycle MAX_LATENCY-1 after the first data word; txd returns to 0x0707…07.
- Bench flips rxd bit 5 on 2 separate words while in CHECK, mode 2 -> error_count = 2, error pulses on exactly those 2 cycles.
- tx_rst_n asserted in CHECK with error_count = 7 -> all outputs return to reset values immediately; a new start yields a clean run with error_count = 0.
- start and stop pulsed in the same cycle while IDLE -> remains IDLE, busy stays 0.
